// File: rtl/pot_weight_encoder.sv
// Streaming signed-integer to power-of-two {sign, exponent} quantizer.
// Optional macro POT_ROUND_NEAREST_EN enables round-to-nearest on the exponent.
module pot_weight_encoder #(
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int INPUT_BIT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INPUT_BIT_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WEIGHT_BIT_WIDTH-1:0] out_code,
  output logic                        out_zero,
  output logic                        out_sat
);

  localparam int EW   = WEIGHT_BIT_WIDTH - 1;
  localparam int EMAX = (1 << EW) - 1;
  localparam int IW   = $clog2(INPUT_BIT_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_ROUND,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic                        sign_q, sign_d;
  logic [INPUT_BIT_WIDTH-1:0]  mag_q, mag_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [WEIGHT_BIT_WIDTH-1:0] code_q, code_d;
  logic                        zero_q, zero_d;
  logic                        sat_q, sat_d;

  logic [INPUT_BIT_WIDTH-1:0]  abs_in;
  logic                        bit_k;
  logic                        rnd_up;
  int                          e_int;
  logic [EW-1:0]               exp_v;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_code  = code_q;
  assign out_zero  = zero_q;
  assign out_sat   = sat_q;

  // Most negative input wraps to 2^(N-1), which is its true magnitude.
  assign abs_in = in_data[INPUT_BIT_WIDTH-1] ?
                  (~in_data + 1'b1) : in_data;

  always_comb begin
    bit_k  = 1'b0;
    rnd_up = 1'b0;
    for (int j = 0; j < INPUT_BIT_WIDTH; j++) begin
      if (idx_q == IW'(j)) begin
        bit_k = mag_q[j];
`ifdef POT_ROUND_NEAREST_EN
        if (j > 0) rnd_up = mag_q[(j > 0) ? j - 1 : 0];
`endif
      end
    end
    e_int = int'(idx_q) + int'(rnd_up);
    exp_v = (e_int > EMAX) ? EW'(EMAX) : EW'(e_int);
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    idx_d   = idx_q;
    code_d  = code_q;
    zero_d  = zero_q;
    sat_d   = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[INPUT_BIT_WIDTH-1];
          mag_d   = abs_in;
          idx_d   = IW'(INPUT_BIT_WIDTH - 1);
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (bit_k) begin
          state_d = S_ROUND;
        end else if (idx_q == '0) begin
          code_d  = '0;
          zero_d  = 1'b1;
          sat_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_ROUND: begin
        code_d  = {sign_q, exp_v};
        zero_d  = 1'b0;
        sat_d   = (e_int > EMAX);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      zero_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      zero_q  <= zero_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_pot_weight_encoder.sv
// Randomized scoreboard bench for pot_weight_encoder (8-bit and 10-bit inputs).
// Reference model works from log2/rounding arithmetic on integers.
module tb_pot_weight_encoder;

  typedef struct {
    logic [3:0] code;
    logic       zero;
    logic       sat;
    int         lat;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_code;
  logic       out_zero;
  logic       out_sat;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [9:0] b_in_data = '0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b1;
  logic [3:0] b_out_code;
  logic       b_out_zero;
  logic       b_out_sat;

  pot_weight_encoder #(.WEIGHT_BIT_WIDTH(4), .INPUT_BIT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_zero(out_zero), .out_sat(out_sat)
  );

  pot_weight_encoder #(.WEIGHT_BIT_WIDTH(4), .INPUT_BIT_WIDTH(10)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_code(b_out_code), .out_zero(b_out_zero), .out_sat(b_out_sat)
  );

  int   cyc = 0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;
  bit   bp_mode = 1'b0;
  exp_t q[$];
  exp_t qb[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(string nm, int act, int req);
    tot_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, req, cyc);
  endtask

  function automatic exp_t model(int v, int n);
    exp_t r;
    int   mag, k, e;
    r.code = '0;
    r.zero = 1'b0;
    r.sat  = 1'b0;
    r.acc  = 0;
    if (v == 0) begin
      r.zero = 1'b1;
      r.lat  = n;
      return r;
    end
    mag = (v < 0) ? -v : v;
    k = 0;
    while ((1 << (k + 1)) <= mag) k++;
    e = k;
`ifdef POT_ROUND_NEAREST_EN
    if (2 * mag >= 3 * (1 << k)) e = k + 1;
`endif
    if (e > 7) begin
      e = 7;
      r.sat = 1'b1;
    end
    r.code = {(v < 0) ? 1'b1 : 1'b0, 3'(e)};
    r.lat  = n - k + 1;
    return r;
  endfunction

  // Output handshake driver: random backpressure unless forced off.
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_mode ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor for the 8-bit instance.
  initial begin
    exp_t       cur;
    bit         seen = 1'b0;
    bit         hs = 1'b0;
    logic [3:0] h_code = '0;
    logic       h_zero = 1'b0;
    logic       h_sat = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
        hs = 1'b0;
        continue;
      end
      if (hs) begin
        chk("in_ready_after_hs", int'(in_ready), 1);
        chk("valid_low_after_hs", int'(out_valid), 0);
        hs = 1'b0;
      end
      if (out_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            chk("unexpected_output_qsize", q.size(), 1);
          end else begin
            cur = q.pop_front();
            chk("code", int'(out_code), int'(cur.code));
            chk("zero", int'(out_zero), int'(cur.zero));
            chk("sat", int'(out_sat), int'(cur.sat));
            chk("latency", cyc - cur.acc, cur.lat);
          end
          h_code = out_code;
          h_zero = out_zero;
          h_sat = out_sat;
          seen = 1'b1;
        end else begin
          chk("hold_code", int'(out_code), int'(h_code));
          chk("hold_zero", int'(out_zero), int'(h_zero));
          chk("hold_sat", int'(out_sat), int'(h_sat));
        end
        chk("in_ready_low_done", int'(in_ready), 0);
        if (out_ready) begin
          seen = 1'b0;
          hs = 1'b1;
        end
      end
    end
  end

  // Monitor for the 10-bit instance (always ready, one cycle per result).
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      if (rst_n && b_out_valid) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_output_qsize", qb.size(), 1);
        end else begin
          cur = qb.pop_front();
          chk("b_code", int'(b_out_code), int'(cur.code));
          chk("b_zero", int'(b_out_zero), int'(cur.zero));
          chk("b_sat", int'(b_out_sat), int'(cur.sat));
          chk("b_latency", cyc - cur.acc, cur.lat);
        end
      end
    end
  end

  task automatic send_a(int v);
    exp_t e;
    int   t = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = v[7:0];
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 300) begin
        tot_cnt++;
        $display("FAIL accept_timeout: in_ready stuck at 0 for value %0d", v);
        break;
      end
    end
    e = model(v, 8);
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_b(int v);
    exp_t e;
    int   t = 0;
    @(posedge clk);
    #1;
    b_in_valid = 1'b1;
    b_in_data  = v[9:0];
    forever begin
      @(negedge clk);
      if (b_in_ready) break;
      t++;
      if (t > 300) begin
        tot_cnt++;
        $display("FAIL b_accept_timeout: in_ready stuck at 0 for value %0d", v);
        break;
      end
    end
    e = model(v, 10);
    e.acc = cyc + 1;
    qb.push_back(e);
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_in_data  = 10'($urandom);
  endtask

  task automatic drain_a();
    int t = 0;
    while ((q.size() != 0 || out_valid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_a_qsize", q.size(), 0);
  endtask

  task automatic drain_b();
    int t = 0;
    while ((qb.size() != 0 || b_out_valid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_b_qsize", qb.size(), 0);
  endtask

  int edge_vals[14] = '{0, 1, -1, -128, 127, -12, 12, 3, -3, 64, 96, -96, 2, -2};
  int b_vals[13] = '{400, -400, 511, -512, 191, 192, -192, 383, 0, 1, -1, -12, 255};

  initial begin
    int v;
    int t;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_code", int'(out_code), 0);
    chk("rst_out_zero", int'(out_zero), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (edge_vals[i]) send_a(edge_vals[i]);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0)
        v = edge_vals[$urandom_range(0, 13)];
      else
        v = int'($urandom_range(0, 255)) - 128;
      send_a(v);
    end
    drain_a();

    // Hold the first result for several cycles while a second input waits.
    bp_mode = 1'b1;
    send_a(-12);
    fork
      begin
        t = 0;
        while (!out_valid && t < 50) begin
          @(posedge clk);
          t++;
        end
        repeat (5) @(posedge clk);
        bp_mode = 1'b0;
      end
    join_none
    send_a(100);
    drain_a();

    // Reset while scanning: result dropped, nothing stale afterwards.
    send_a(3);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      chk("post_rst_no_valid", int'(out_valid), 0);
    end
    send_a(-12);
    send_a(0);
    drain_a();

    foreach (b_vals[i]) send_b(b_vals[i]);
    for (int n = 0; n < 40; n++) send_b(int'($urandom_range(0, 1023)) - 512);
    drain_b();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
